// File: rtl/game_pkg.sv
// Shared defaults and state type for the barrel scheduler.
package game_pkg;

    localparam int unsigned N_BARRELS_DEF       = 10;
    localparam int unsigned COOLDOWN_CYCLES_DEF = 32_500_000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READY    = 2'd1,
        ST_COOLDOWN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_slot_picker.sv
// Combinational round-robin picker: first free slot at or above ptr, wrapping to 0.
module rr_slot_picker #(
    parameter int unsigned N_SLOTS = 10,
    parameter int unsigned PTR_W   = 4
) (
    input  logic [N_SLOTS-1:0] free_mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_SLOTS-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any_free
);

    logic              found;
    logic [PTR_W-1:0]  idx;
    int unsigned       slot_w;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_free  = |free_mask;
        found     = 1'b0;
        idx       = '0;
        slot_w    = 0;
        for (int unsigned i = 0; i < N_SLOTS; i++) begin
            slot_w = 32'(ptr) + i;
            if (slot_w >= N_SLOTS)
                slot_w = slot_w - N_SLOTS;
            idx = PTR_W'(slot_w);
            if (!found && free_mask[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/barrel_scheduler.sv
// Launches Kong's barrels onto a fixed slot pool with a post-launch cooldown
// and retires slots on done/hit pulses.
module barrel_scheduler
    import game_pkg::*;
#(
    parameter int unsigned N_BARRELS       = N_BARRELS_DEF,
    parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
    parameter int unsigned MAX_ACTIVE      = N_BARRELS_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           game_en,
    input  logic                           throw_req,
    input  logic [N_BARRELS-1:0]           barrel_done,
    input  logic [N_BARRELS-1:0]           barrel_hit,
    output logic [N_BARRELS-1:0]           barrel_start,
    output logic [N_BARRELS-1:0]           barrel_active,
    output logic                           throw_ack,
    output logic                           cooldown_busy,
    output logic [$clog2(N_BARRELS+1)-1:0] active_count
);

    localparam int unsigned PW = (N_BARRELS > 1) ? $clog2(N_BARRELS) : 1;
    localparam int unsigned CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
    localparam int unsigned AW = $clog2(N_BARRELS + 1);

    sched_state_t         state;
    logic [CW-1:0]        cnt;
    logic [PW-1:0]        ptr;

    logic [N_BARRELS-1:0] grant;
    logic [PW-1:0]        grant_idx;
    logic                 any_free;
    logic                 can_launch;
    logic [N_BARRELS-1:0] active_nxt;
    logic [AW-1:0]        count_nxt;

    rr_slot_picker #(
        .N_SLOTS (N_BARRELS),
        .PTR_W   (PW)
    ) u_picker (
        .free_mask (~barrel_active),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_free  (any_free)
    );

    // Retires and the launch land in the same cycle; the count follows the merged vector.
    always_comb begin
        can_launch = (state == ST_READY) && throw_req && any_free &&
                     (32'(active_count) < MAX_ACTIVE);
        active_nxt = barrel_active & ~(barrel_done | barrel_hit);
        if (can_launch)
            active_nxt = active_nxt | grant;
        count_nxt = '0;
        for (int unsigned i = 0; i < N_BARRELS; i++)
            count_nxt = count_nxt + AW'(active_nxt[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ptr           <= '0;
            barrel_start  <= '0;
            barrel_active <= '0;
            throw_ack     <= 1'b0;
            cooldown_busy <= 1'b0;
            active_count  <= '0;
        end else if (!game_en) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            barrel_start  <= '0;
            barrel_active <= '0;
            throw_ack     <= 1'b0;
            cooldown_busy <= 1'b0;
            active_count  <= '0;
        end else begin
            barrel_start  <= '0;
            throw_ack     <= 1'b0;
            barrel_active <= active_nxt;
            active_count  <= count_nxt;
            case (state)
                ST_IDLE: state <= ST_READY;
                ST_READY: begin
                    if (can_launch) begin
                        barrel_start  <= grant;
                        throw_ack     <= 1'b1;
                        ptr           <= (grant_idx == PW'(N_BARRELS - 1)) ? '0 : grant_idx + PW'(1);
                        cnt           <= CW'(COOLDOWN_CYCLES - 1);
                        cooldown_busy <= 1'b1;
                        state         <= ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    if (cnt == '0) begin
                        cooldown_busy <= 1'b0;
                        state         <= ST_READY;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    cooldown_busy <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_scheduler.sv
// Self-checking bench: two schedulers (MAX_ACTIVE 10 and 2) share stimulus and
// are compared every cycle against a behavioural slot-pool model.
module tb_barrel_scheduler;

    localparam int N  = 10;
    localparam int CD = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         game_en;
    logic         throw_req;
    logic [N-1:0] done;
    logic [N-1:0] hit;

    logic [N-1:0] d_start  [2];
    logic [N-1:0] d_active [2];
    logic         d_ack    [2];
    logic         d_busy   [2];
    logic [3:0]   d_cnt    [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    barrel_scheduler #(.N_BARRELS(N), .COOLDOWN_CYCLES(CD), .MAX_ACTIVE(10)) dut (
        .clk(clk), .rst(rst), .game_en(game_en), .throw_req(throw_req),
        .barrel_done(done), .barrel_hit(hit),
        .barrel_start(d_start[0]), .barrel_active(d_active[0]),
        .throw_ack(d_ack[0]), .cooldown_busy(d_busy[0]), .active_count(d_cnt[0])
    );

    barrel_scheduler #(.N_BARRELS(N), .COOLDOWN_CYCLES(CD), .MAX_ACTIVE(2)) dut_lim (
        .clk(clk), .rst(rst), .game_en(game_en), .throw_req(throw_req),
        .barrel_done(done), .barrel_hit(hit),
        .barrel_start(d_start[1]), .barrel_active(d_active[1]),
        .throw_ack(d_ack[1]), .cooldown_busy(d_busy[1]), .active_count(d_cnt[1])
    );

    // Model: game running flag, pool occupancy, cycles of cooldown remaining.
    logic [N-1:0] m_act   [2];
    int           m_ptr   [2];
    int           m_cool  [2];
    bit           m_idle  [2];
    logic [N-1:0] e_start [2];
    logic         e_ack   [2];
    int           max_act [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            int launch;
            launch     = -1;
            e_start[m] = '0;
            e_ack[m]   = 1'b0;
            if (rst) begin
                m_act[m] = '0; m_ptr[m] = 0; m_cool[m] = 0; m_idle[m] = 1'b1;
            end else if (!game_en) begin
                m_act[m] = '0; m_cool[m] = 0; m_idle[m] = 1'b1;
            end else if (m_idle[m]) begin
                m_idle[m] = 1'b0;
            end else begin
                if (m_cool[m] == 0 && throw_req && $countones(m_act[m]) < max_act[m])
                    for (int i = 0; i < N; i++) begin
                        int s;
                        s = (m_ptr[m] + i) % N;
                        if (launch < 0 && !m_act[m][s]) launch = s;
                    end
                if (m_cool[m] > 0) m_cool[m]--;
                m_act[m] = m_act[m] & ~(done | hit);
                if (launch >= 0) begin
                    m_act[m][launch]   = 1'b1;
                    e_start[m][launch] = 1'b1;
                    e_ack[m]           = 1'b1;
                    m_ptr[m]           = (launch + 1) % N;
                    m_cool[m]          = CD;
                end
            end
        end
    endtask

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("start%0d", m),  32'(d_start[m]),  32'(e_start[m]));
            check($sformatf("active%0d", m), 32'(d_active[m]), 32'(m_act[m]));
            check($sformatf("ack%0d", m),    32'(d_ack[m]),    32'(e_ack[m]));
            check($sformatf("busy%0d", m),   32'(d_busy[m]),   32'(m_cool[m] > 0));
            check($sformatf("count%0d", m),  32'(d_cnt[m]),    32'($countones(m_act[m])));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        int cyc;
        int s_cyc [$];
        logic [N-1:0] s_val [$];
        bit lim_third;
        bit ok;

        max_act[0] = 10;
        max_act[1] = 2;
        for (int m = 0; m < 2; m++) begin
            m_act[m] = '0; m_ptr[m] = 0; m_cool[m] = 0; m_idle[m] = 1'b1;
        end

        rst = 1'b1; game_en = 1'b1; throw_req = 1'b0; done = '0; hit = '0;
        step();
        step();
        check("reset_start", 32'(d_start[0]), 32'h0);
        check("reset_count", 32'(d_cnt[0]), 32'h0);

        // Test 1: held request, launches on slots 0,1,2 spaced by CD+1.
        rst = 1'b0; throw_req = 1'b1;
        lim_third = 1'b0;
        for (cyc = 1; cyc <= 12; cyc++) begin
            step();
            if (d_start[0] != '0) begin
                s_cyc.push_back(cyc);
                s_val.push_back(d_start[0]);
            end
            if (d_start[1] == 10'h004) lim_third = 1'b1;
        end
        check("t1_nlaunch", 32'(s_val.size()), 32'd3);
        if (s_val.size() == 3) begin
            check("t1_first", 32'(s_val[0]), 32'h001);
            check("t1_second", 32'(s_val[1]), 32'h002);
            check("t1_third", 32'(s_val[2]), 32'h004);
            check("t1_gap", 32'(s_cyc[1] - s_cyc[0]), 32'd5);
            check("t1_gap2", 32'(s_cyc[2] - s_cyc[1]), 32'd5);
        end
        check("t1_count", 32'(d_cnt[0]), 32'd3);
        check("t3_lim_blocked", 32'(lim_third), 32'd0);

        // Test 4: drop game_en in 2nd cooldown cycle, then restart.
        step();
        game_en = 1'b0;
        step();
        check("t4_active", 32'(d_active[0]), 32'h0);
        check("t4_count", 32'(d_cnt[0]), 32'h0);
        check("t4_busy", 32'(d_busy[0]), 32'h0);
        game_en = 1'b1;
        step();
        check("t4_no_early", 32'(d_start[0]), 32'h0);
        step();
        check("t4_restart_slot", 32'(d_start[0]), 32'h008);

        // Test 2: fill the pool, confirm blocking, then a done pulse frees slot 3.
        ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            step();
            if (d_active[0] == 10'h3FF) ok = 1'b1;
        end
        check("t2_fill", 32'(ok), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t2_blocked", 32'(d_start[0] | 10'(d_ack[0])), 32'h0);
        end
        done = 10'h008;
        step();
        done = '0;
        check("t2_retire", 32'(d_active[0]), 32'h3F7);
        step();
        check("t2_wrap_launch", 32'(d_start[0]), 32'h008);

        // Test 5: simultaneous retire, ignored hit and launch.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (d_start[0] == 10'h002) ok = 1'b1;
        end
        check("t5_second_launch", 32'(ok), 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (!d_busy[0]) ok = 1'b1;
        end
        check("t5_ready", 32'(ok), 32'd1);
        done = 10'h002; hit = 10'h020;
        step();
        done = '0; hit = '0;
        check("t5_start", 32'(d_start[0]), 32'h004);
        check("t5_active", 32'(d_active[0]), 32'h005);
        check("t5_count", 32'(d_cnt[0]), 32'd2);

        // Test 6: reset mid-cooldown.
        rst = 1'b1;
        step();
        check("t6_active", 32'(d_active[0]), 32'h0);
        check("t6_busy", 32'(d_busy[0]), 32'h0);
        check("t6_count", 32'(d_cnt[0]), 32'h0);
        rst = 1'b0;
        step();
        step();
        check("t6_ptr0", 32'(d_start[0]), 32'h001);

        // Randomized phase.
        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            game_en   = ($urandom_range(0, 49) != 0);
            throw_req = ($urandom_range(0, 9) < 7);
            for (int b = 0; b < N; b++) begin
                done[b] = ($urandom_range(0, 29) == 0);
                hit[b]  = ($urandom_range(0, 39) == 0);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
